rptr_handler_lvl: RTL and testbench
===================================

Name: rptr_handler_lvl

Overview:
- Parameterised read-side pointer handler for the asynchronous FIFO, in the read clock domain.
- Keeps the binary and Gray read pointers and generates a registered empty flag from the synchronised Gray write pointer.
- Also provides a registered fill level, an almost-empty flag, the memory read address and the read strobe.
- Drives the FIFO RAM read port and the read-to-write pointer synchroniser.

Parameters:
- ADDR_WIDTH, 4, RAM address width; FIFO depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits (extra wrap bit).
- AE_THRESH, 2, almost_empty asserts when fill level <= AE_THRESH; legal range 0..2**ADDR_WIDTH-1.

Ports:
- r_clk  input  1  read-domain clock, all state on rising edge.
- r_rst  input  1  asynchronous active-high reset.
- r_en  input  1  read request from consumer.
- g_wptr_sync  input  ADDR_WIDTH+1  Gray write pointer, already 2-flop synchronised into r_clk.
- r_addr  output  ADDR_WIDTH  RAM read address, equal to b_rptr[ADDR_WIDTH-1:0].
- r_ren  output  1  accepted read strobe to RAM (combinational).
- b_rptr  output  ADDR_WIDTH+1  binary read pointer.
- g_rptr  output  ADDR_WIDTH+1  Gray read pointer, sent to the write-domain synchroniser.
- empty  output  1  registered empty flag.
- almost_empty  output  1  registered almost-empty flag.
- rd_fill  output  ADDR_WIDTH+1  registered occupancy seen by the read side, range 0..2**ADDR_WIDTH.
- underflow  output  1  sticky underflow flag (see Optional Feature).

Behaviour:
- Reset (async assert; release synchronised externally):
  - b_rptr=0, g_rptr=0, rd_fill=0.
  - empty=1, almost_empty=1, underflow=0.
- Read accept:
  - r_ren = r_en & ~empty. This is the only condition that advances the pointer.
  - r_en while empty is ignored: no pointer move, no RAM strobe.
- Next-state logic:
  - b_rptr_next = b_rptr + r_ren, mod 2**(ADDR_WIDTH+1); wraps naturally from all-ones to 0.
  - g_rptr_next = b_rptr_next ^ (b_rptr_next >> 1).
  - g_rptr is registered from g_rptr_next, so g_rptr always encodes the same value as b_rptr in the same cycle. It changes by exactly one bit per advance.
- Write-pointer decode:
  - wptr_bin = Gray-to-binary of g_wptr_sync. Each bit i is the XOR of bits MSB..i.
- Flags:
  - empty is registered from (g_rptr_next == g_wptr_sync). Consequently, reading the last word sets empty on the next edge, with no bubble.
  - rd_fill is registered from (wptr_bin - b_rptr_next) mod 2**(ADDR_WIDTH+1).
  - almost_empty is registered from (fill_next <= AE_THRESH).
  - All three flags update on the same edge.
- Latency:
  - Pointer, empty, rd_fill and almost_empty respond 1 r_clk after r_en.
  - A write becomes visible 1 r_clk after g_wptr_sync changes; the synchroniser latency is external.
- Pessimism:
  - Because of the sync lag, rd_fill may under-report and empty may assert early.
  - Neither may ever over-report: no false non-empty.
- Simultaneous events:
  - If a read of the last word coincides with a g_wptr_sync increment, the flags are computed from both new values. empty stays 0 and rd_fill equals 1.
- Full FIFO:
  - When wptr_bin - b_rptr == 2**ADDR_WIDTH, rd_fill = 2**ADDR_WIDTH (MSB set, low bits 0).
  - empty = 0 in this case, because the wrap bits differ.
- Reset mid-operation: all outputs return to their reset values immediately on r_rst assertion, independent of r_clk.
- Not in scope: FIFO memory, synchronisers, write-side logic.

Optional Feature:
- Macro: RPTR_UNDERFLOW_EN.
- Defined:
  - underflow is a sticky register.
  - It sets on any r_clk edge where r_en=1 and empty=1.
  - It clears only on r_rst.
- Not defined:
  - underflow is tied to 0 and no register is inferred.
  - All other behaviour is identical.

Test Plan (ADDR_WIDTH=4, AE_THRESH=2):
- Reset check:
  - Stimulus: assert r_rst mid-clock with no r_clk edge.
  - Response: b_rptr=0, g_rptr=0, empty=1, almost_empty=1, rd_fill=0 immediately.
- Read on empty:
  - Stimulus: g_wptr_sync=0, r_en held high 5 cycles.
  - Response: r_ren=0, b_rptr stays 0. With RPTR_UNDERFLOW_EN, underflow=1 after the first edge and stays 1 until reset.
- Fill and drain:
  - Stimulus: g_wptr_sync=Gray(3)=5'b00010, then r_en high 3 cycles.
  - Response before reads: rd_fill=3, almost_empty=0.
  - Response during reads: rd_fill 2, 1, 0; almost_empty=1 from the first read; empty=1 on the edge after the third read.
- Wrap-around:
  - Stimulus: stream 40 writes/reads.
  - Response: b_rptr wraps 31->0, g_rptr 5'b10000 -> 5'b00000, and exactly one g_rptr bit changes per read.
- Full:
  - Stimulus: b_rptr=0, g_wptr_sync=Gray(16)=5'b11000.
  - Response: rd_fill=16, empty=0.
- Simultaneous:
  - Stimulus: rd_fill=1, r_en=1, and the same cycle g_wptr_sync advances by one.
  - Response: empty stays 0, rd_fill=1.

Source files
------------

// File: rtl/rptr_handler_lvl_if.sv
// Read-side bus of the async-FIFO read pointer handler.
// master: consumer side (drives r_en and the synchronised write pointer).
// slave:  the pointer handler itself.
interface rptr_handler_lvl_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  r_en;
    logic [ADDR_WIDTH:0]   g_wptr_sync;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_ren;
    logic [ADDR_WIDTH:0]   b_rptr;
    logic [ADDR_WIDTH:0]   g_rptr;
    logic                  empty;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   rd_fill;
    logic                  underflow;

    modport master (
        output r_en, g_wptr_sync,
        input  r_addr, r_ren, b_rptr, g_rptr, empty, almost_empty, rd_fill, underflow
    );

    modport slave (
        input  r_en, g_wptr_sync,
        output r_addr, r_ren, b_rptr, g_rptr, empty, almost_empty, rd_fill, underflow
    );
endinterface

// File: rtl/rptr_handler_lvl.sv
// Read-side pointer handler for an asynchronous FIFO (read clock domain).
// Keeps binary/Gray read pointers and registers empty, almost_empty and the
// fill level seen from the read side. Flags are computed from the next-state
// pointer so that reading the last word raises empty on the very next edge.
// Optional sticky underflow flag: define RPTR_UNDERFLOW_EN to enable it;
// otherwise underflow is tied low and no register is built.
module rptr_handler_lvl #(
    parameter int ADDR_WIDTH = 4,
    parameter int AE_THRESH  = 2
) (
    input logic               r_clk,
    input logic               r_rst,
    rptr_handler_lvl_if.slave bus
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AE_LIM = PW'(AE_THRESH);

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits from the MSB down to it.
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] b_rptr_q, b_rptr_d;
    logic [PW-1:0] g_rptr_q, g_rptr_d;
    logic [PW-1:0] fill_q, fill_d;
    logic          empty_q, empty_d;
    logic          ae_q, ae_d;
    logic [PW-1:0] wptr_bin;
    logic          r_ren;

    // A read is accepted only when the FIFO is not empty.
    assign r_ren = bus.r_en & ~empty_q;

    // Next-state pointers and flags, all derived from the post-read pointer.
    always_comb begin
        b_rptr_d = b_rptr_q + {{ADDR_WIDTH{1'b0}}, r_ren};
        g_rptr_d = bin2gray(b_rptr_d);
        wptr_bin = gray2bin(bus.g_wptr_sync);
        fill_d   = wptr_bin - b_rptr_d;
        empty_d  = (g_rptr_d == bus.g_wptr_sync);
        ae_d     = (fill_d <= AE_LIM);
    end

    // Pointer and flag registers; reset leaves the FIFO looking empty.
    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            b_rptr_q <= '0;
            g_rptr_q <= '0;
            fill_q   <= '0;
            empty_q  <= 1'b1;
            ae_q     <= 1'b1;
        end else begin
            b_rptr_q <= b_rptr_d;
            g_rptr_q <= g_rptr_d;
            fill_q   <= fill_d;
            empty_q  <= empty_d;
            ae_q     <= ae_d;
        end
    end

`ifdef RPTR_UNDERFLOW_EN
    logic underflow_q, underflow_d;

    assign underflow_d = underflow_q | (bus.r_en & empty_q);

    // Sticky record of any read attempted while empty; cleared only by reset.
    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= underflow_d;
        end
    end

    assign bus.underflow = underflow_q;
`else
    assign bus.underflow = 1'b0;
`endif

    assign bus.r_ren        = r_ren;
    assign bus.r_addr       = b_rptr_q[ADDR_WIDTH-1:0];
    assign bus.b_rptr       = b_rptr_q;
    assign bus.g_rptr       = g_rptr_q;
    assign bus.empty        = empty_q;
    assign bus.almost_empty = ae_q;
    assign bus.rd_fill      = fill_q;
endmodule

// File: tb/tb_rptr_handler_lvl.sv
// Directed bench for rptr_handler_lvl (ADDR_WIDTH=4, AE_THRESH=2).
module tb_rptr_handler_lvl;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

`ifdef RPTR_UNDERFLOW_EN
    localparam bit UF_EN = 1'b1;
`else
    localparam bit UF_EN = 1'b0;
`endif

    rptr_handler_lvl_if #(.ADDR_WIDTH(4)) bus ();

    rptr_handler_lvl #(.ADDR_WIDTH(4), .AE_THRESH(2)) dut (
        .r_clk (clk),
        .r_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       r_en;
        logic [4:0] gw;
        logic       ren;
        logic [4:0] b;
        logic [4:0] g;
        logic       e;
        logic       ae;
        logic [4:0] fill;
        logic       uf;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // {b, g, empty, ae, fill, uf, addr}
    function automatic logic [31:0] obs();
        return {10'd0, bus.b_rptr, bus.g_rptr, bus.empty, bus.almost_empty,
                bus.rd_fill, bus.underflow, bus.r_addr};
    endfunction

    function automatic logic [31:0] mk(input logic [4:0] b, input logic [4:0] g,
                                       input logic e, input logic ae,
                                       input logic [4:0] fill, input logic uf);
        return {10'd0, b, g, e, ae, fill, uf & UF_EN, b[3:0]};
    endfunction

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ {1'b0, b[4:1]};
    endfunction

    initial begin
        logic [4:0] exp_b;
        logic [4:0] prev_g;
        logic [4:0] w;
        logic       wrap_seen;
        int         onebit_bad;

        checks = 0;
        failures = 0;

        // r_en, gw, ren, b, g, empty, ae, fill, uf
        tbl[0]  = '{1'b1, 5'b00000, 1'b0, 5'd0, 5'b00000, 1'b1, 1'b1, 5'd0, 1'b1};
        tbl[1]  = '{1'b1, 5'b00000, 1'b0, 5'd0, 5'b00000, 1'b1, 1'b1, 5'd0, 1'b1};
        tbl[2]  = '{1'b1, 5'b00000, 1'b0, 5'd0, 5'b00000, 1'b1, 1'b1, 5'd0, 1'b1};
        tbl[3]  = '{1'b1, 5'b00000, 1'b0, 5'd0, 5'b00000, 1'b1, 1'b1, 5'd0, 1'b1};
        tbl[4]  = '{1'b1, 5'b00000, 1'b0, 5'd0, 5'b00000, 1'b1, 1'b1, 5'd0, 1'b1};
        tbl[5]  = '{1'b0, 5'b00010, 1'b0, 5'd0, 5'b00000, 1'b0, 1'b0, 5'd3, 1'b1};
        tbl[6]  = '{1'b1, 5'b00010, 1'b1, 5'd1, 5'b00001, 1'b0, 1'b1, 5'd2, 1'b1};
        tbl[7]  = '{1'b1, 5'b00010, 1'b1, 5'd2, 5'b00011, 1'b0, 1'b1, 5'd1, 1'b1};
        tbl[8]  = '{1'b1, 5'b00010, 1'b1, 5'd3, 5'b00010, 1'b1, 1'b1, 5'd0, 1'b1};
        tbl[9]  = '{1'b1, 5'b00010, 1'b0, 5'd3, 5'b00010, 1'b1, 1'b1, 5'd0, 1'b1};
        tbl[10] = '{1'b0, 5'b00110, 1'b0, 5'd3, 5'b00010, 1'b0, 1'b1, 5'd1, 1'b1};
        tbl[11] = '{1'b1, 5'b00111, 1'b1, 5'd4, 5'b00110, 1'b0, 1'b1, 5'd1, 1'b1};
        tbl[12] = '{1'b1, 5'b00111, 1'b1, 5'd5, 5'b00111, 1'b1, 1'b1, 5'd0, 1'b1};

        // Asynchronous reset with no clock edge yet
        rst = 1'b0;
        bus.r_en = 1'b0;
        bus.g_wptr_sync = 5'd0;
        #2 rst = 1'b1;
        #1;
        chk("reset_async", obs(), mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0));
        @(posedge clk);
        #1 rst = 1'b0;

        // Table: read on empty, fill/drain, simultaneous read+write
        for (int i = 0; i < 13; i++) begin
            bus.r_en = tbl[i].r_en;
            bus.g_wptr_sync = tbl[i].gw;
            @(negedge clk);
            chk($sformatf("ren_v%0d", i), {31'd0, bus.r_ren}, {31'd0, tbl[i].ren});
            @(posedge clk);
            #1;
            chk($sformatf("state_v%0d", i), obs(),
                mk(tbl[i].b, tbl[i].g, tbl[i].e, tbl[i].ae, tbl[i].fill, tbl[i].uf));
        end

        // Wrap-around stream: writer stays two ahead, reader reads every cycle
        exp_b = 5'd5;
        bus.r_en = 1'b0;
        bus.g_wptr_sync = gray(5'd7);
        @(posedge clk);
        #1;
        chk("stream_prime", obs(), mk(5'd5, gray(5'd5), 1'b0, 1'b1, 5'd2, 1'b1));
        wrap_seen = 1'b0;
        onebit_bad = 0;
        for (int i = 0; i < 40; i++) begin
            prev_g = bus.g_rptr;
            w = exp_b + 5'd3;
            bus.r_en = 1'b1;
            bus.g_wptr_sync = gray(w);
            @(posedge clk);
            #1;
            exp_b = exp_b + 5'd1;
            if ($countones(prev_g ^ bus.g_rptr) != 1) onebit_bad++;
            if (prev_g == 5'b10000 && bus.g_rptr == 5'b00000 && bus.b_rptr == 5'd0)
                wrap_seen = 1'b1;
            chk($sformatf("stream_%0d", i), obs(),
                mk(exp_b, gray(exp_b), 1'b0, 1'b1, 5'd2, 1'b1));
        end
        chk("stream_onebit", onebit_bad, 0);
        chk("stream_wrap", {31'd0, wrap_seen}, 32'd1);

        // Reset in the middle of operation, away from any edge
        bus.r_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("reset_midop", obs(), mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0));
        @(posedge clk);
        #1 rst = 1'b0;

        // Full FIFO: write pointer 16 ahead
        bus.g_wptr_sync = 5'b11000;
        @(posedge clk);
        #1;
        chk("full", obs(), mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd16, 1'b0));
        bus.r_en = 1'b1;
        @(negedge clk);
        chk("full_ren", {31'd0, bus.r_ren}, 32'd1);
        @(posedge clk);
        #1;
        chk("full_read1", obs(), mk(5'd1, 5'b00001, 1'b0, 1'b0, 5'd15, 1'b0));
        bus.r_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
